// File: rtl/alu_pkg.sv
// alu_pkg: shared operation encodings and datapath width for the alu
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: sll/srl/sra barrel shifter selected by alu_op
module alu_shifter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         a,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic [3:0]              alu_op,
  output logic [XLEN-1:0]         y
);
  import alu_pkg::*;
  logic signed [XLEN-1:0] sra;
  assign sra = $signed(a) >>> shamt;
  always_comb y = alu_op == ALU_SLL ? a << shamt : alu_op == ALU_SRA ? sra : a >> shamt;
endmodule

// File: rtl/alu.sv
// alu: combinational integer alu with a registered result/zero stage
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q
);
  import alu_pkg::*;
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] sum, diff, shifted;
  logic slt, sltu;
  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;
  assign slt  = $signed(operand_a) < $signed(operand_b);
  assign sltu = operand_a < operand_b;
  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .a      (operand_a),
    .shamt  (operand_b[SW-1:0]),
    .alu_op (alu_op),
    .y      (shifted)
  );
  always_comb begin
    case (alu_op)
      ALU_ADD, ALU_AUIPC:        result = sum;
      ALU_SUB:                   result = diff;
      ALU_SLL, ALU_SRL, ALU_SRA: result = shifted;
      ALU_SLT:                   result = XLEN'(slt);
      ALU_SLTU:                  result = XLEN'(sltu);
      ALU_XOR:                   result = operand_a ^ operand_b;
      ALU_OR:                    result = operand_a | operand_b;
      ALU_AND:                   result = operand_a & operand_b;
      ALU_LUI:                   result = operand_b;
      default:                   result = '0;
    endcase
  end
  assign zero = result == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed self-checking bench for alu
module tb_alu;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_op;
  logic [31:0] result, result_q;
  logic        zero, zero_q;
  int passed = 0;
  int total  = 0;

  alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_op    (alu_op),
    .result    (result),
    .zero      (zero),
    .result_q  (result_q),
    .zero_q    (zero_q)
  );

  always #5 clk = ~clk;

  // reference computed with wide integer arithmetic, not bit-level logic
  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    longint m  = longint'(1) << 32;
    longint ux = longint'(x);
    longint uy = longint'(y);
    int     sx = int'(x);
    int     sy = int'(y);
    int     sh = int'(y % 32);
    int     t;
    case (op)
      4'd0, 4'd11: return 32'((ux + uy) % m);
      4'd1:        return 32'((ux - uy + m) % m);
      4'd2:        return 32'((ux * (longint'(1) << sh)) % m);
      4'd3:        return (sx < sy) ? 32'd1 : 32'd0;
      4'd4:        return (ux < uy) ? 32'd1 : 32'd0;
      4'd5:        return x ^ y;
      4'd6:        return 32'(ux / (longint'(1) << sh));
      4'd7: begin
        t = sx >>> sh;
        return 32'(t);
      end
      4'd8:        return x | y;
      4'd9:        return x & y;
      4'd10:       return y;
      default:     return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; alu_op = ALU_ADD; operand_a = 32'd10; operand_b = 32'd20;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd0) $display("FAIL reset_result_q got %h want 00000000", result_q); else passed++;
    total++;
    if (zero_q !== 1'b1) $display("FAIL reset_zero_q got %b want 1", zero_q); else passed++;
    total++;
    if (result !== 32'd30) $display("FAIL reset_comb_result got %h want 0000001e", result); else passed++;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL reset_hold got %h/%b want 00000000/1", result_q, zero_q); else passed++;
  endtask

  task automatic test_directed();
    vec_t v[$] = '{
      '{ALU_ADD,   32'hFFFFFFFF, 32'h1,        32'h0},
      '{ALU_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000},
      '{ALU_SUB,   32'd5,        32'd10,       32'hFFFFFFFB},
      '{ALU_SUB,   32'd10,       32'd10,       32'h0},
      '{ALU_SLL,   32'h1,        32'h21,       32'h2},
      '{ALU_SRL,   32'hFFFFFFFF, 32'h1,        32'h7FFFFFFF},
      '{ALU_SRA,   32'hF0000000, 32'h4,        32'hFF000000},
      '{ALU_SRA,   32'h80000000, 32'd31,       32'hFFFFFFFF},
      '{ALU_SRL,   32'h80000000, 32'hFFFFFFFF, 32'h1},
      '{ALU_SLT,   32'hFFFFFFFF, 32'h1,        32'h1},
      '{ALU_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0},
      '{ALU_SLT,   32'h80000000, 32'h0,        32'h1},
      '{ALU_SLTU,  32'h1,        32'hFFFFFFFF, 32'h1},
      '{ALU_SLT,   32'h12345678, 32'h12345678, 32'h0},
      '{ALU_XOR,   32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987},
      '{ALU_OR,    32'h12345678, 32'h87654321, 32'h97755779},
      '{ALU_AND,   32'h12345678, 32'h87654321, 32'h02244220},
      '{ALU_LUI,   32'hDEADBEEF, 32'h0,        32'h0},
      '{ALU_LUI,   32'hDEADBEEF, 32'hABCD0000, 32'hABCD0000},
      '{ALU_AUIPC, 32'h12345678, 32'hABCD0000, 32'hBE015678},
      '{4'd12,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0},
      '{4'd13,     32'h1,        32'h2,        32'h0},
      '{4'd15,     32'hDEADBEEF, 32'h1,        32'h0}
    };
    rst = 1'b0;
    foreach (v[i]) begin
      alu_op = v[i].op; operand_a = v[i].a; operand_b = v[i].b;
      #1;
      total++;
      if (result !== v[i].exp)
        $display("FAIL directed_result[%0d] op=%0d a=%h b=%h got %h want %h", i, v[i].op, v[i].a, v[i].b, result, v[i].exp);
      else passed++;
      total++;
      if (zero !== (v[i].exp == 32'h0))
        $display("FAIL directed_zero[%0d] op=%0d got %b want %b", i, v[i].op, zero, v[i].exp == 32'h0);
      else passed++;
    end
  endtask

  task automatic test_random_comb();
    logic [31:0] exp;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      alu_op    = 4'($urandom_range(0, 15));
      operand_a = $urandom;
      operand_b = ($urandom_range(0, 7) == 0) ? operand_a : $urandom;
      #1;
      exp = model(alu_op, operand_a, operand_b);
      total++;
      if (result !== exp || zero !== (exp == 32'h0))
        $display("FAIL random_comb op=%0d a=%h b=%h got %h/%b want %h/%b", alu_op, operand_a, operand_b, result, zero, exp, exp == 32'h0);
      else passed++;
    end
  endtask

  task automatic test_register();
    rst = 1'b1; alu_op = ALU_SUB; operand_a = 32'd7; operand_b = 32'd3;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL reg_reset got %h/%b want 00000000/1", result_q, zero_q); else passed++;
    rst = 1'b0; alu_op = ALU_ADD; operand_a = 32'd10; operand_b = 32'd20;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd30 || zero_q !== 1'b0) $display("FAIL reg_add got %h/%b want 0000001e/0", result_q, zero_q); else passed++;
    alu_op = 4'd13;
    #1;
    total++;
    if (result_q !== 32'd30) $display("FAIL reg_hold_between_edges got %h want 0000001e", result_q); else passed++;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL reg_undef got %h/%b want 00000000/1", result_q, zero_q); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      alu_op    = 4'($urandom_range(0, 15));
      operand_a = $urandom;
      operand_b = $urandom;
      exp = model(alu_op, operand_a, operand_b);
      @(posedge clk); #1;
      total++;
      if (result_q !== exp || zero_q !== (exp == 32'h0))
        $display("FAIL b2b[%0d] op=%0d got %h/%b want %h/%b", i, alu_op, result_q, zero_q, exp, exp == 32'h0);
      else passed++;
    end
    rst = 1'b1; alu_op = ALU_OR; operand_a = 32'h5; operand_b = 32'hA0;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) $display("FAIL b2b_reset_override got %h/%b want 00000000/1", result_q, zero_q); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (result_q !== 32'hA5 || zero_q !== 1'b0) $display("FAIL b2b_after_reset got %h/%b want 000000a5/0", result_q, zero_q); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_comb();
    test_register();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The parameter list SHALL be: XLEN, default 32, datapath width in bits; all other values are fixed for XLEN=32.
REQ-002 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for the output register stage.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: operand_a  input  32  first operand (rs1 or PC).
REQ-006 Port: operand_b  input  32  second operand (rs2, immediate, or U-immediate).
REQ-007 Port: alu_op  input  4  operation select.
REQ-008 Port: result  output  32  combinational result.
REQ-009 Port: zero  output  1  combinational flag, 1 when result == 0.
REQ-010 Port: result_q  output  32  result registered on clk.
REQ-011 Port: zero_q  output  1  zero registered on clk.

Function
REQ-012 result and zero SHALL be purely combinational from operand_a, operand_b and alu_op, with zero latency, and SHALL be independent of clk and rst.
REQ-013 The alu_op encodings SHALL be:
- 0 ADD: a+b
- 1 SUB: a-b
- 2 SLL: a << b[4:0]
- 3 SLT: signed a<b ? 1 : 0
- 4 SLTU: unsigned a<b ? 1 : 0
- 5 XOR
- 6 SRL: logical a >> b[4:0]
- 7 SRA: arithmetic a >>> b[4:0]
- 8 OR
- 9 AND
- 10 LUI: result = b, operand_a ignored
- 11 AUIPC: a+b
REQ-014 Add and subtract SHALL wrap modulo 2^32, with no carry or overflow output (0x7FFFFFFF+1 = 0x80000000; 0xFFFFFFFF+1 = 0).
REQ-015 Shift amounts SHALL use only operand_b[4:0]; operand_b[31:5] SHALL be ignored (shamt 33 acts as 1).
REQ-016 SRL SHALL zero-fill; SRA SHALL replicate operand_a[31].
REQ-017 SLT and SLTU SHALL produce 0x00000000 or 0x00000001 only; equal operands SHALL give 0.
REQ-018 Undefined encodings 12 to 15 SHALL produce result = 0 and zero = 1.
REQ-019 zero SHALL equal 1 exactly when result == 32'h0, for every operation including SLT/SLTU false, LUI of 0, and undefined ops.
REQ-020 On each rising clk edge with rst low, result_q SHALL load result and zero_q SHALL load zero, giving 1-cycle latency.
REQ-021 The design SHALL have no handshake and no state other than result_q and zero_q; a new operation is accepted every cycle.

Reset
REQ-022 While rst is high at a rising clk edge, result_q SHALL load 0 and zero_q SHALL load 1, overriding the data path.
REQ-023 rst SHALL NOT affect result or zero.
REQ-024 After rst deasserts, the first edge SHALL capture the current combinational result.

Structure
REQ-025 A shared package alu_pkg SHALL hold the 4-bit alu_op encodings (ALU_ADD to ALU_AUIPC) and XLEN, for use by the decoder and by benches.
REQ-026 One sub-module, alu_shifter (SLL/SRL/SRA, 5-bit shamt), is natural. Add/sub, compare, logic and the output mux SHALL stay in alu.

Verification
REQ-027 ADD 0xFFFFFFFF + 0x1 -> result 0x00000000, zero 1; ADD 0x7FFFFFFF + 1 -> 0x80000000, zero 0.
REQ-028 SUB 5 - 10 -> 0xFFFFFFFB, zero 0; SUB 10 - 10 -> 0, zero 1.
REQ-029 Shifts:
- SLL 0x1 by 0x21 -> 0x2
- SRL 0xFFFFFFFF by 1 -> 0x7FFFFFFF
- SRA 0xF0000000 by 4 -> 0xFF000000
- SRA 0x80000000 by 31 -> 0xFFFFFFFF
REQ-030 Compares:
- SLT 0xFFFFFFFF < 1 -> 1
- SLTU 0xFFFFFFFF < 1 -> 0, zero 1
- SLT 0x80000000 < 0 -> 1
- SLTU 1 < 0xFFFFFFFF -> 1
REQ-031 Logic and upper-immediate ops:
- XOR 0xFFFFFFFF ^ 0x12345678 -> 0xEDCBA987
- OR 0x12345678 | 0x87654321 -> 0x97755779
- LUI a=0xDEADBEEF, b=0 -> 0, zero 1
- AUIPC 0x12345678 + 0xABCD0000 -> 0xBE015678
REQ-032 Register stage:
- rst high one edge -> result_q 0, zero_q 1.
- Then ADD 10+20 -> result_q 30, zero_q 0 one edge later.
- alu_op 13 -> result 0, zero 1.
